// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector host driver: default operand
// dimensions, derived sizes and the run-control state encoding.
package mvm_pkg;

    localparam int DEF_NROWS_A = 3;
    localparam int DEF_NCOLS_A = 3;
    localparam int DEF_NROWS_B = 3;
    localparam int DEF_NCOLS_B = 1;

    localparam int A_SIZE = DEF_NROWS_A * DEF_NCOLS_A;
    localparam int B_SIZE = DEF_NROWS_B * DEF_NCOLS_B;
    localparam int NRES   = DEF_NROWS_A * DEF_NCOLS_B;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        RECV,
        DONE
    } mvm_state_t;

endpackage

// File: rtl/mvm_drv_out_reg.sv
// Operand-stream output register: holds m_data/m_valid until the controller
// loads the next operand after a transfer (or on a new run).
module mvm_drv_out_reg (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_valid,
    input  logic signed [7:0] load_data,
    output logic signed [7:0] m_data,
    output logic              m_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_valid <= load_valid;
            m_data  <= load_valid ? load_data : '0;
        end
    end

endmodule

// File: rtl/mvm_host_driver.sv
// Host-side driver for a streaming matrix-vector multiplier: stores A and B,
// streams them out with valid/ready, and collects the results with overflow.
module mvm_host_driver
    import mvm_pkg::*;
#(
    parameter int NROWS_A = DEF_NROWS_A,
    parameter int NCOLS_A = DEF_NCOLS_A,
    parameter int NROWS_B = DEF_NROWS_B,
    parameter int NCOLS_B = DEF_NCOLS_B,
    localparam int RES_AW = ((NROWS_A * NCOLS_B) > 1) ? $clog2(NROWS_A * NCOLS_B) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_addr,
    input  logic signed [7:0]        cfg_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic signed [7:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic signed [15:0]       s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_overflow,
    input  logic [RES_AW-1:0]        res_addr,
    output logic signed [15:0]       res_data,
    output logic                     res_ovf,
    output logic                     ovf_any
);

    localparam int A_SZ  = NROWS_A * NCOLS_A;
    localparam int B_SZ  = NROWS_B * NCOLS_B;
    localparam int OP_SZ = A_SZ + B_SZ;
    localparam int N_RES = NROWS_A * NCOLS_B;

    mvm_state_t state, state_next;

    logic [3:0]          op_idx;
    logic [RES_AW-1:0]   res_idx;
    logic signed [7:0]   op_mem  [OP_SZ];
    logic signed [15:0]  res_mem [N_RES];
    logic [N_RES-1:0]    ovf_flags;

    logic start_ok, m_fire, s_fire, a_last, b_last, res_last, cfg_open;
    logic load, load_valid;
    logic signed [7:0] load_data;

    assign cfg_open = (state == IDLE) || (state == DONE);
    assign start_ok = start && cfg_open;
    assign m_fire   = m_valid && m_ready;
    assign s_fire   = s_valid && s_ready;
    assign a_last   = op_idx == 4'(A_SZ - 1);
    assign b_last   = op_idx == 4'(B_SZ - 1);
    assign res_last = res_idx == RES_AW'(N_RES - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start)              state_next = SEND_A;
            SEND_A:     if (m_fire && a_last)   state_next = SEND_B;
            SEND_B:     if (m_fire && b_last)   state_next = RECV;
            RECV:       if (s_fire && res_last) state_next = DONE;
            default:                            state_next = IDLE;
        endcase
    end

    // The next operand is loaded into the output register on the same edge as
    // the transfer, so the A->B boundary produces no bubble.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        s_ready    = 1'b0;
        load       = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    load       = 1'b1;
                    load_valid = 1'b1;
                    load_data  = op_mem[0];
                end
            end
            SEND_A: begin
                busy = 1'b1;
                if (m_fire) begin
                    load       = 1'b1;
                    load_valid = 1'b1;
                    load_data  = a_last ? op_mem[A_SZ] : op_mem[op_idx + 4'd1];
                end
            end
            SEND_B: begin
                busy = 1'b1;
                if (m_fire) begin
                    load       = 1'b1;
                    load_valid = !b_last;
                    if (!b_last) load_data = op_mem[4'(A_SZ) + op_idx + 4'd1];
                end
            end
            RECV: begin
                busy    = 1'b1;
                s_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            op_idx <= '0;
        end else if (m_fire && (state == SEND_A || state == SEND_B)) begin
            if ((state == SEND_A && a_last) || (state == SEND_B && b_last)) op_idx <= '0;
            else                                                            op_idx <= op_idx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            res_idx   <= '0;
            ovf_flags <= '0;
            for (int unsigned i = 0; i < N_RES; i++) res_mem[i] <= '0;
        end else if (s_fire) begin
            res_mem[res_idx]   <= s_data;
            ovf_flags[res_idx] <= s_overflow;
            res_idx            <= res_last ? '0 : res_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && cfg_open && ({1'b0, cfg_addr} < 5'(OP_SZ)))
            op_mem[cfg_addr] <= cfg_data;
    end

    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        if (int'(res_addr) < N_RES) begin
            res_data = res_mem[res_addr];
            res_ovf  = ovf_flags[res_addr];
        end
    end

    assign ovf_any = |ovf_flags;

    mvm_drv_out_reg u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_valid (load_valid),
        .load_data  (load_data),
        .m_data     (m_data),
        .m_valid    (m_valid)
    );

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed + randomized bench for mvm_host_driver with a behavioural
// multiplier model answering the operand stream.
module tb_mvm_host_driver;

    localparam int NRA = 3, NCA = 3, NRB = 3, NCB = 1;
    localparam int NA = NRA * NCA, NB = NRB * NCB, NT = NA + NB, NR = NRA * NCB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic signed [7:0] cfg_data = '0;
    logic start = 1'b0;
    logic busy, done;
    logic signed [7:0] m_data;
    logic m_valid;
    logic m_ready = 1'b0;
    logic signed [15:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic s_overflow = 1'b0;
    logic [1:0] res_addr = '0;
    logic signed [15:0] res_data;
    logic res_ovf, ovf_any;

    int vectors = 0;
    int miscompares = 0;

    logic signed [7:0]  opnd [NT];
    logic signed [15:0] exp_res [NR];
    logic               exp_ovf [NR];
    logic signed [7:0]  got [$];

    always #5 clk = ~clk;

    mvm_host_driver #(
        .NROWS_A (NRA),
        .NCOLS_A (NCA),
        .NROWS_B (NRB),
        .NCOLS_B (NCB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_overflow (s_overflow),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .ovf_any    (ovf_any)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Matrix product of the stored operands; index i*NCB+j, A and B row-major.
    task automatic model(input int ovf_idx);
        for (int i = 0; i < NRA; i++)
            for (int j = 0; j < NCB; j++) begin
                int sum = 0;
                for (int k = 0; k < NCA; k++)
                    sum += int'(opnd[i*NCA + k]) * int'(opnd[NA + k*NCB + j]);
                exp_res[i*NCB + j] = 16'(sum);
                exp_ovf[i*NCB + j] = (sum > 32767) || (sum < -32768);
            end
        if (ovf_idx >= 0) begin
            exp_res[ovf_idx] = 16'sh7FFF;
            exp_ovf[ovf_idx] = 1'b1;
        end
    endtask

    task automatic load_ops();
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = opnd[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // hook 3: pulse start/cfg_we in SEND_B; hook 4: pulse s_valid in SEND_A.
    task automatic stream(input int n_stop, input bit rnd, input int hook);
        logic signed [7:0] held = '0;
        bit hold_pending = 1'b0;
        int budget = 400;
        got.delete();
        while (got.size() < n_stop && budget > 0) begin
            @(negedge clk);
            budget--;
            start = 1'b0; cfg_we = 1'b0; s_valid = 1'b0;
            if (hold_pending) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(held));
            end
            m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (hook == 3 && got.size() == 10) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'sd99;
            end
            if (hook == 4 && got.size() == 2) begin
                s_valid = 1'b1; s_data = 16'sh1234; s_overflow = 1'b1;
            end
            hold_pending = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) got.push_back(m_data);
        end
        start = 1'b0; cfg_we = 1'b0; s_valid = 1'b0;
        if (budget == 0) check("stream_timeout", 32'd0, 32'd1);
    endtask

    task automatic respond();
        int r = 0;
        int budget = 60;
        bit accepted;
        while (r < NR && budget > 0) begin
            s_valid = 1'b1; s_data = exp_res[r]; s_overflow = exp_ovf[r];
            accepted = s_ready;
            @(negedge clk);
            budget--;
            if (accepted) r++;
        end
        s_valid = 1'b0;
        if (budget == 0) check("respond_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_full(input bit rnd, input int hook, input int ovf_idx);
        model(ovf_idx);
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_m_valid", 32'(m_valid), 32'd1);
        check("start_m_data", 32'(m_data), 32'(opnd[0]));
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_ovf_clr", 32'(ovf_any), 32'd0);
        stream(NT, rnd, hook);
        for (int i = 0; i < got.size(); i++) check("seq", 32'(got[i]), 32'(opnd[i]));
        @(negedge clk);
        m_ready = 1'b0;
        check("recv_m_valid", 32'(m_valid), 32'd0);
        check("recv_s_ready", 32'(s_ready), 32'd1);
        res_addr = 2'd0;
        #1;
        check("recv_res0_clear", 32'(res_data), 32'd0);
        check("recv_ovf_clear", 32'(ovf_any), 32'd0);
        respond();
        check("done_done", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_s_ready", 32'(s_ready), 32'd0);
        for (int r = 0; r < NR; r++) begin
            res_addr = 2'(r);
            #1;
            check("res_data", 32'(res_data), 32'(exp_res[r]));
            check("res_ovf", 32'(res_ovf), 32'(exp_ovf[r]));
        end
        check("ovf_any", 32'(ovf_any), (ovf_idx >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_ovf_any", 32'(ovf_any), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NA; i++) opnd[i] = 8'(i + 1);
        for (int i = 0; i < NB; i++) opnd[NA + i] = 8'(i + 1);
        load_ops();

        run_full(1'b0, 0, -1);
        run_full(1'b1, 0, -1);
        run_full(1'b1, 0, 1);

        // abort after five operand transfers
        model(-1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream(5, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        check("abort_m_data", 32'(m_data), 32'd0);
        reset = 1'b0;
        m_ready = 1'b0;
        run_full(1'b1, 0, -1);

        run_full(1'b1, 3, -1);
        run_full(1'b0, 0, -1);
        run_full(1'b1, 4, -1);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NT; i++) opnd[i] = 8'(int'($urandom_range(0, 200)) - 100);
            load_ops();
            run_full(1'b1, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mvm_host_driver.md
MVM_HOST_DRIVER -- requirements
Module: mvm_host_driver

Interface
REQ-001 The block SHALL have parameter NROWS_A, default 3, rows of matrix A.
REQ-002 The block SHALL have parameter NCOLS_A, default 3, columns of A.
REQ-003 The block SHALL have parameter NROWS_B, default 3, rows of vector/matrix B.
REQ-004 The block SHALL have parameter NCOLS_B, default 1, columns of B; NRES = NROWS_A*NCOLS_B.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-006 The block SHALL have the following load and control ports:
- cfg_we input 1, operand write strobe.
- cfg_addr input 4, operand index 0..A_SIZE+B_SIZE-1 (A row-major first, then B).
- cfg_data input 8 signed, operand value.
- start input 1, begin a run.
- busy output 1, run in progress.
- done output 1, results valid.
REQ-007 The block SHALL have the following operand-stream and result-stream ports:
- m_data output 8 signed, operand stream to the multiplier.
- m_valid output 1, m_data valid.
- m_ready input 1, multiplier accepts.
- s_data input 16 signed, result from the multiplier.
- s_valid input 1, result valid.
- s_ready output 1, block accepts result.
- s_overflow input 1, overflow flag accompanying s_data.
REQ-008 The block SHALL have the following result read-back ports:
- res_addr input clog2(NRES), result select.
- res_data output 16 signed, selected result, combinational.
- res_ovf output 1, overflow of selected result.
- ovf_any output 1, OR of all stored overflow flags.

Function
REQ-009 The FSM SHALL have states IDLE, SEND_A, SEND_B, RECV, DONE.
REQ-010 In IDLE or DONE, cfg_we SHALL write cfg_data to operand slot cfg_addr; writes in other states and out-of-range addresses SHALL be ignored.
REQ-011 start in IDLE or DONE SHALL clear done, result buffer and overflow flags, and enter SEND_A, with m_valid=1 and m_data=A[0] on the next cycle; start in any other state SHALL be ignored.
REQ-012 A transfer SHALL occur on m_valid&&m_ready; m_data and m_valid SHALL be held stable while m_valid&&!m_ready.
REQ-013 With m_ready held high, operands SHALL be issued one per cycle: A[0..A_SIZE-1] in SEND_A, then B[0..B_SIZE-1] in SEND_B, with no bubble at the A/B boundary.
REQ-014 Transfer of the last B element SHALL move the FSM to RECV; m_valid SHALL be 0 and s_ready 1 on the following cycle.
REQ-015 s_ready SHALL be 1 only in RECV. Each s_valid&&s_ready SHALL store s_data and s_overflow at the result index, which increments from 0.
REQ-016 Acceptance of result NRES-1 SHALL enter DONE; the next cycle SHALL show done=1, busy=0, s_ready=0.
REQ-017 busy SHALL be 1 in SEND_A, SEND_B and RECV; done SHALL be 1 only in DONE and stay set until the next accepted start.
REQ-018 s_valid outside RECV SHALL be ignored, with no store.
REQ-019 Operand counter and result index SHALL wrap to 0 at the end of each phase.
REQ-020 Operand contents SHALL persist across runs, so a repeated start re-sends identical data.

Reset
REQ-021 Reset SHALL force IDLE, m_valid=0, m_data=0, s_ready=0, busy=0, done=0, all counters 0, result buffer and overflow flags 0; operand storage need not be cleared.
REQ-022 Reset asserted mid-run SHALL abort within one cycle, with no partial completion flagged.

Structure
REQ-023 A shared package mvm_pkg SHALL hold the state enum and the derived constants A_SIZE, B_SIZE, NRES.
REQ-024 The output register stage (m_data/m_valid hold logic) SHALL be one sub-module, mvm_drv_out_reg; operand and result storage SHALL be flat register arrays.

Verification
REQ-025 The bench SHALL load A=1..9 and B=1,2,3, start with a behavioural multiplier model, and read res 0..2 = 14, 32, 50, with done=1 and ovf_any=0.
REQ-026 The bench SHALL toggle m_ready randomly and check that m_data never changes while m_valid&&!m_ready and that the 12-value sequence arrives in order.
REQ-027 The bench SHALL return result 1 as 0x7FFF with s_overflow=1 and check res_ovf(res_addr=1)=1, res_ovf(0)=0, ovf_any=1.
REQ-028 The bench SHALL assert reset after 5 operand transfers and check the outputs on the next cycle: m_valid=0, busy=0, done=0, IDLE; a new start SHALL re-send from A[0].
REQ-029 The bench SHALL pulse start and cfg_we during SEND_B and check that the sequence is unaffected and operand memory is unchanged.
REQ-030 The bench SHALL pulse s_valid during SEND_A and check that no result is stored and the result index stays 0.
